// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads the instruction memory, assembles one- or two-word
// instructions and hands them to the control unit over a valid/ready handshake.
module instr_fetch #(
    parameter logic [15:0] RESET_PC  = 16'd0,
    parameter logic [7:0]  OP_LOADIM = 8'd33,
    parameter logic [7:0]  OP_JUMPZ  = 8'd35,
    parameter logic [7:0]  OP_JUMPNZ = 8'd39,
    parameter logic [7:0]  OP_JUMP   = 8'd40,
    parameter logic [7:0]  OP_ENDOP  = 8'd42
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  opcode,
    output logic [7:0]  operand,
    output logic        has_operand,
    input  logic        branch_en,
    input  logic [15:0] branch_target,
    output logic [15:0] pc,
    output logic        halted,
    output logic [2:0]  dbg_state
);

    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both high; while instr_valid is high the instruction fields
    // and pc hold steady, and branch_en/branch_target are sampled only on that edge.

    localparam logic [2:0] S_OP_ADDR  = 3'd0;
    localparam logic [2:0] S_OP_DATA  = 3'd1;
    localparam logic [2:0] S_ARG_ADDR = 3'd2;
    localparam logic [2:0] S_ARG_DATA = 3'd3;
    localparam logic [2:0] S_VALID    = 3'd4;
    localparam logic [2:0] S_HALT     = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  operand_q, operand_d;
    logic        has_operand_q, has_operand_d;
    logic        instr_valid_q, instr_valid_d;
    logic        halted_q, halted_d;
    logic        is_two_word;

    // Only the low byte of a memory word carries instruction content.
    logic unused_mem_hi;
    assign unused_mem_hi = ^mem_data[15:8];

    assign is_two_word = (mem_data[7:0] == OP_LOADIM) || (mem_data[7:0] == OP_JUMPZ) ||
                         (mem_data[7:0] == OP_JUMPNZ) || (mem_data[7:0] == OP_JUMP);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        opcode_d      = opcode_q;
        operand_d     = operand_q;
        has_operand_d = has_operand_q;
        case (state_q)
            S_OP_ADDR: state_d = S_OP_DATA;
            S_OP_DATA: begin
                opcode_d      = mem_data[7:0];
                operand_d     = 8'd0;
                pc_d          = pc_q + 16'd1;
                has_operand_d = is_two_word;
                state_d       = is_two_word ? S_ARG_ADDR : S_VALID;
            end
            S_ARG_ADDR: state_d = S_ARG_DATA;
            S_ARG_DATA: begin
                operand_d = mem_data[7:0];
                pc_d      = pc_q + 16'd1;
                state_d   = S_VALID;
            end
            S_VALID: begin
                if (instr_ready) begin
                    if (opcode_q == OP_ENDOP) begin
                        state_d = S_HALT;
                    end else begin
                        if (branch_en) begin
                            pc_d = branch_target;
                        end
                        state_d = S_OP_ADDR;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_OP_ADDR;
        endcase
        // Status flags are registered copies of the next state decode.
        instr_valid_d = (state_d == S_VALID);
        halted_d      = (state_d == S_HALT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_OP_ADDR;
            pc_q          <= RESET_PC;
            opcode_q      <= 8'd0;
            operand_q     <= 8'd0;
            has_operand_q <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            opcode_q      <= opcode_d;
            operand_q     <= operand_d;
            has_operand_q <= has_operand_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign has_operand = has_operand_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run against a
// program-level reference model of instruction sequencing.
module tb_instr_fetch;

    logic        clock;
    logic        reset;
    logic [15:0] mem_addr, mem_data;
    logic        instr_valid, instr_ready;
    logic [7:0]  opcode, operand;
    logic        has_operand, branch_en;
    logic [15:0] branch_target, pc;
    logic        halted;
    logic [2:0]  dbg_state;

    logic [15:0] mem_addr2, mem_data2;
    logic        instr_valid2;
    logic [7:0]  opcode2, operand2;
    logic        has_operand2;
    logic [15:0] pc2;
    logic        halted2;
    logic [2:0]  dbg_state2;

    logic [15:0] mem  [0:65535];
    logic [15:0] mem2 [0:65535];

    int tests_run = 0;
    int tests_failed = 0;

    instr_fetch dut (
        .clock(clock), .reset(reset), .mem_addr(mem_addr), .mem_data(mem_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode),
        .operand(operand), .has_operand(has_operand), .branch_en(branch_en),
        .branch_target(branch_target), .pc(pc), .halted(halted), .dbg_state(dbg_state)
    );

    instr_fetch #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clock(clock), .reset(reset), .mem_addr(mem_addr2), .mem_data(mem_data2),
        .instr_valid(instr_valid2), .instr_ready(1'b1), .opcode(opcode2),
        .operand(operand2), .has_operand(has_operand2), .branch_en(1'b0),
        .branch_target(16'd0), .pc(pc2), .halted(halted2), .dbg_state(dbg_state2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read memories: data appears the cycle after the address is sampled.
    always @(posedge clock) begin
        mem_data  <= mem[mem_addr];
        mem_data2 <= mem2[mem_addr2];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_two_word(input logic [7:0] op);
        return (op == 8'd33) || (op == 8'd35) || (op == 8'd39) || (op == 8'd40);
    endfunction

    initial begin
        logic [7:0]  s_op, s_arg;
        logic [15:0] s_pc;
        logic [15:0] mpc;
        logic [7:0]  m_op, m_arg;
        bit          m_two, checked, acc_pending;
        int          lat, accepts, cycles;

        reset = 1'b1;
        instr_ready = 1'b1;
        branch_en = 1'b0;
        branch_target = 16'd0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]  = 16'd0;
            mem2[i] = 16'd0;
        end
        mem[0] = 16'd33; mem[1] = 16'd5; mem[2] = 16'd5;
        mem[3] = 16'd40; mem[4] = 16'd20; mem[20] = 16'd41;
        mem[12] = 16'd42;
        mem2[16'hFFFF] = 16'd33; mem2[0] = 16'd7;

        tick();
        tick();
        chk("rst_pc", pc, 16'd0);
        chk("rst_mem_addr", mem_addr, 16'd0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_opcode", opcode, 8'd0);
        chk("rst_operand", operand, 8'd0);
        chk("rst_has_operand", has_operand, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_wrap_pc", pc2, 16'hFFFF);

        // Two-word instruction latency: valid after the 4th edge.
        reset = 1'b0;
        tick();
        tick();
        chk("wrap_pc_rolls_to_0", pc2, 16'h0000);
        tick();
        chk("lat2_not_yet_valid", instr_valid, 1'b0);
        tick();
        chk("lat2_valid", instr_valid, 1'b1);
        chk("lat2_opcode", opcode, 8'd33);
        chk("lat2_operand", operand, 8'd5);
        chk("lat2_has_operand", has_operand, 1'b1);
        chk("lat2_pc", pc, 16'd2);
        chk("wrap_opcode", opcode2, 8'd33);
        chk("wrap_operand", operand2, 8'd7);
        chk("wrap_pc", pc2, 16'd1);

        // Accepted on the next edge; one-word instruction 3 cycles later.
        tick();
        chk("acc_valid_drop", instr_valid, 1'b0);
        tick();
        tick();
        chk("lat1_valid", instr_valid, 1'b1);
        chk("lat1_opcode", opcode, 8'd5);
        chk("lat1_operand", operand, 8'd0);
        chk("lat1_has_operand", has_operand, 1'b0);
        chk("lat1_pc", pc, 16'd3);

        // Backpressure with a stray branch request that must not be taken.
        instr_ready = 1'b0;
        branch_en = 1'b1;
        branch_target = 16'd100;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", instr_valid, 1'b1);
            chk("bp_opcode", opcode, 8'd5);
            chk("bp_pc", pc, 16'd3);
        end
        instr_ready = 1'b1;
        branch_en = 1'b0;
        tick();
        chk("bp_accept", instr_valid, 1'b0);
        instr_ready = 1'b0;
        tick();
        chk("bp_next_addr", mem_addr, 16'd3);
        branch_en = 1'b1;
        branch_target = 16'd99;
        tick();
        branch_en = 1'b0;
        chk("idle_branch_ignored", pc, 16'd4);
        tick();
        tick();
        chk("jump_valid", instr_valid, 1'b1);
        chk("jump_opcode", opcode, 8'd40);
        chk("jump_operand", operand, 8'd20);
        chk("jump_pc", pc, 16'd5);

        // Taken branch: first address after acceptance is the target.
        instr_ready = 1'b1;
        branch_en = 1'b1;
        branch_target = 16'd20;
        tick();
        chk("br_mem_addr", mem_addr, 16'd20);
        instr_ready = 1'b0;
        branch_en = 1'b0;
        tick();
        tick();
        chk("br_opcode", opcode, 8'd41);
        chk("br_valid", instr_valid, 1'b1);
        chk("br_pc", pc, 16'd21);

        instr_ready = 1'b1;
        branch_en = 1'b1;
        branch_target = 16'd12;
        tick();
        chk("br2_mem_addr", mem_addr, 16'd12);
        instr_ready = 1'b0;
        branch_en = 1'b0;
        tick();
        tick();
        chk("endop_opcode", opcode, 8'd42);
        chk("endop_pc", pc, 16'd13);

        // Halt: branch on the accepting edge is ignored, pc frozen.
        instr_ready = 1'b1;
        branch_en = 1'b1;
        branch_target = 16'd50;
        tick();
        chk("halt_halted", halted, 1'b1);
        chk("halt_valid", instr_valid, 1'b0);
        for (int i = 0; i < 20; i++) begin
            instr_ready = 1'($urandom_range(0, 1));
            branch_en = 1'($urandom_range(0, 1));
            branch_target = 16'($urandom);
            tick();
            chk("halt_hold_halted", halted, 1'b1);
            chk("halt_hold_valid", instr_valid, 1'b0);
            chk("halt_hold_pc", pc, 16'd13);
        end
        instr_ready = 1'b0;
        branch_en = 1'b0;

        reset = 1'b1;
        #1;
        chk("rerst_pc", pc, 16'd0);
        chk("rerst_halted", halted, 1'b0);

        // Reset in the middle of fetching an operand.
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_pre_pc", pc, 16'd1);
        chk("mid_pre_opcode", opcode, 8'd33);
        reset = 1'b1;
        #1;
        chk("mid_async_pc", pc, 16'd0);
        chk("mid_async_opcode", opcode, 8'd0);
        chk("mid_async_operand", operand, 8'd0);
        chk("mid_async_has_operand", has_operand, 1'b0);
        chk("mid_async_valid", instr_valid, 1'b0);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_refetch_opcode", opcode, 8'd33);
        chk("mid_refetch_operand", operand, 8'd5);
        chk("mid_refetch_pc", pc, 16'd2);

        // Randomized program; the model walks it instruction by instruction.
        reset = 1'b1;
        tick();
        for (int a = 0; a < 256; a++) begin
            case ($urandom_range(0, 5))
                0: mem[a] = 16'd33;
                1: mem[a] = 16'd35;
                2: mem[a] = 16'd39;
                3: mem[a] = 16'd40;
                default: begin
                    mem[a] = 16'($urandom);
                    if (mem[a][7:0] == 8'd42) mem[a][7:0] = 8'd0;
                end
            endcase
        end
        reset = 1'b0;
        mpc = 16'd0;
        lat = 0;
        checked = 1'b0;
        acc_pending = 1'b0;
        accepts = 0;
        cycles = 0;
        while (accepts < 40 && cycles < 1000) begin
            tick();
            cycles++;
            lat++;
            if (acc_pending) begin
                accepts++;
                mpc = branch_en ? branch_target : mpc + (m_two ? 16'd2 : 16'd1);
                lat = 0;
                checked = 1'b0;
            end
            m_op  = mem[mpc][7:0];
            m_two = model_two_word(m_op);
            m_arg = m_two ? mem[16'(mpc + 16'd1)][7:0] : 8'd0;
            if (instr_valid && !checked) begin
                checked = 1'b1;
                chk("rnd_opcode", opcode, m_op);
                chk("rnd_operand", operand, m_arg);
                chk("rnd_has_operand", has_operand, m_two);
                chk("rnd_pc", pc, mpc + (m_two ? 16'd2 : 16'd1));
                chk("rnd_latency", lat, m_two ? 4 : 2);
                s_op = opcode; s_arg = operand; s_pc = pc;
            end else if (instr_valid) begin
                chk("rnd_hold", {opcode, operand, pc}, {s_op, s_arg, s_pc});
            end
            instr_ready = 1'($urandom_range(0, 1));
            branch_en = 1'($urandom_range(0, 1));
            branch_target = 16'($urandom_range(0, 250));
            acc_pending = instr_valid && instr_ready;
        end
        chk("rnd_accept_budget", (accepts >= 40), 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
